// File: rtl/weight_fetch_ctrl.sv
// Weight-store load controller: walks every phase of a layer, loads each
// 36-word weight vector from the store and hands it downstream over valid/ready.
module weight_fetch_ctrl #(
    parameter int         NUM_PHASE = 8,
    parameter int         TIMEOUT   = 16,
    parameter int         DATA_LEN  = 8,
    parameter logic [3:0] LAYER0    = 4'd0,
    parameter logic [3:0] LAYER1    = 4'd1,
    parameter logic [3:0] LAYER2    = 4'd2,
    parameter logic [3:0] LAYER3    = 4'd3,
    parameter logic [3:0] AFFINE    = 4'd4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               layer,
    output logic                     ws_load,
    output logic [3:0]               ws_cs,
    output logic [2:0]               ws_phase,
    input  logic                     ws_valid,
    input  logic [36*DATA_LEN-1:0]   ws_q,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [36*DATA_LEN-1:0]   w_data,
    output logic [2:0]               w_phase,
    output logic                     w_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int              W       = 36 * DATA_LEN;
    localparam int              CW      = $clog2(TIMEOUT);
    localparam logic [2:0]      LAST_PH = 3'(NUM_PHASE - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_UNMASK = CW'(2);

    typedef enum logic [1:0] {IDLE, SETUP, FETCH, HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_nxt, w_valid_nxt, w_last_nxt, done_nxt, err_nxt;
    logic [3:0]    cs_nxt;
    logic [2:0]    ph_nxt, w_phase_nxt;
    logic [W-1:0]  w_data_nxt;
    logic          layer_ok;

    assign layer_ok = (layer == LAYER0) || (layer == LAYER1) || (layer == LAYER2) ||
                      (layer == LAYER3) || (layer == AFFINE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ws_load  <= 1'b0;
            ws_cs    <= '0;
            ws_phase <= '0;
            w_valid  <= 1'b0;
            w_data   <= '0;
            w_phase  <= '0;
            w_last   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ws_load  <= load_nxt;
            ws_cs    <= cs_nxt;
            ws_phase <= ph_nxt;
            w_valid  <= w_valid_nxt;
            w_data   <= w_data_nxt;
            w_phase  <= w_phase_nxt;
            w_last   <= w_last_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_nxt    = ws_load;
        cs_nxt      = ws_cs;
        ph_nxt      = ws_phase;
        w_valid_nxt = w_valid;
        w_data_nxt  = w_data;
        w_phase_nxt = w_phase;
        w_last_nxt  = w_last;
        done_nxt    = 1'b0;
        err_nxt     = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (layer_ok) begin
                        cs_nxt    = layer;
                        ph_nxt    = '0;
                        err_nxt   = 1'b0;
                        state_nxt = SETUP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            // load low for one cycle lets the store re-init on the new phase
            SETUP: begin
                load_nxt  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = FETCH;
            end
            // store valid is stale from the previous phase until its init clears it
            FETCH: begin
                cnt_nxt = cnt + CW'(1);
                if (ws_valid && (cnt >= CNT_UNMASK)) begin
                    w_data_nxt  = ws_q;
                    w_phase_nxt = ws_phase;
                    w_last_nxt  = (ws_phase == LAST_PH);
                    w_valid_nxt = 1'b1;
                    load_nxt    = 1'b0;
                    state_nxt   = HOLD;
                end else if (cnt == CNT_MAX) begin
                    load_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (w_ready) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    if (ws_phase == LAST_PH) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ph_nxt    = ws_phase + 3'd1;
                        state_nxt = SETUP;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl with a behavioural weight store model;
// a second instance with NUM_PHASE=1 shares the store.
module tb_weight_fetch_ctrl;

    localparam int DL = 8;
    localparam int W  = 36 * DL;
    localparam logic [3:0] L0 = 4'd0, L1 = 4'd1, L2 = 4'd2, L3 = 4'd3;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0, w_ready = 1'b1;
    logic [3:0] layer = '0;

    logic ws_load, w_valid, w_last, busy, done, err;
    logic [3:0] ws_cs;
    logic [2:0] ws_phase, w_phase;
    logic [W-1:0] w_data;

    logic ws_load2, w_valid2, w_last2, busy2, done2, err2;
    logic [3:0] ws_cs2;
    logic [2:0] ws_phase2, w_phase2;
    logic [W-1:0] w_data2;

    logic st_valid = 1'b0;
    logic [W-1:0] st_q = '0;
    int st_cnt = 0;
    bit dead = 1'b0;

    int cyc = 0, total = 0, bad = 0;

    weight_fetch_ctrl #(.NUM_PHASE(8), .TIMEOUT(16), .DATA_LEN(DL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
        .ws_load(ws_load), .ws_cs(ws_cs), .ws_phase(ws_phase),
        .ws_valid(st_valid), .ws_q(st_q),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_phase(w_phase),
        .w_last(w_last), .busy(busy), .done(done), .err(err));

    weight_fetch_ctrl #(.NUM_PHASE(1), .TIMEOUT(16), .DATA_LEN(DL)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .layer(layer),
        .ws_load(ws_load2), .ws_cs(ws_cs2), .ws_phase(ws_phase2),
        .ws_valid(st_valid), .ws_q(st_q),
        .w_valid(w_valid2), .w_ready(w_ready), .w_data(w_data2), .w_phase(w_phase2),
        .w_last(w_last2), .busy(busy2), .done(done2), .err(err2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] rom_vec(input logic [3:0] cs, input logic [2:0] ph);
        logic [W-1:0] v;
        for (int i = 0; i < 36; i++) v[i*DL +: DL] = 8'(i * 7 + int'(ph) * 16 + int'(cs) * 3 + 1);
        return v;
    endfunction

    // store: init on the first load-high edge, valid after the sixth
    always @(posedge clk) begin
        if (ws_load) begin
            if (st_cnt == 0) begin
                st_valid <= 1'b0;
                st_q     <= rom_vec(ws_cs, ws_phase);
            end else if (st_cnt == 5 && !dead) begin
                st_valid <= 1'b1;
            end
            if (st_cnt < 6) st_cnt <= st_cnt + 1;
        end else begin
            st_cnt <= 0;
        end
    end

    typedef struct {int edge_n; logic [2:0] ph; logic last; logic [W-1:0] data;} xfer_t;
    xfer_t exp_q[$], exp2_q[$];
    int done_q[$], done2_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int s, input logic [3:0] cs, input int dph, input int delay);
        int e;
        for (int k = 0; k < 8; k++) begin
            e = s + 9 + 9 * k + ((k >= dph) ? delay : 0);
            exp_q.push_back('{e, 3'(k), (k == 7), rom_vec(cs, 3'(k))});
            if (k == 7) done_q.push_back(e);
        end
    endtask

    task automatic start_run(input logic [3:0] l, output int s);
        s = cyc + 1;
        layer = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_load"}, int'(ws_load), 0);
        chk({tag, "_cs"}, int'(ws_cs), 0);
        chk({tag, "_wsph"}, int'(ws_phase), 0);
        chk({tag, "_wvalid"}, int'(w_valid), 0);
        chkv({tag, "_wdata"}, w_data, '0);
        chk({tag, "_wphase"}, int'(w_phase), 0);
        chk({tag, "_wlast"}, int'(w_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // monitor: sampled on the falling edge, handshake completes on the next rising edge
    logic [2:0] prev_ph = '0;
    always @(negedge clk) begin
        xfer_t x;
        if (w_valid && w_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL xfer_unexpected: got phase %0d expected no transfer", w_phase);
            end else begin
                x = exp_q.pop_front();
                chk("xfer_edge", cyc + 1, x.edge_n);
                chk("xfer_phase", int'(w_phase), int'(x.ph));
                chk("xfer_last", int'(w_last), int'(x.last));
                chkv("xfer_data", w_data, x.data);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got done=1 expected 0 at cycle %0d", cyc);
            end else chk("done_edge", cyc, done_q.pop_front());
        end
        if (w_valid2 && w_ready) begin
            if (exp2_q.size() == 0) begin
                total++; bad++;
                $display("FAIL xfer1_unexpected: got phase %0d expected no transfer", w_phase2);
            end else begin
                x = exp2_q.pop_front();
                chk("xfer1_edge", cyc + 1, x.edge_n);
                chk("xfer1_last", int'(w_last2), int'(x.last));
                chk("xfer1_phase", int'(w_phase2), int'(x.ph));
                chkv("xfer1_data", w_data2, x.data);
            end
        end
        if (done2) begin
            if (done2_q.size() == 0) begin
                total++; bad++;
                $display("FAIL done1_unexpected: got done=1 expected 0 at cycle %0d", cyc);
            end else chk("done1_edge", cyc, done2_q.pop_front());
        end
        if (ws_phase != prev_ph) chk("phase_chg_load_low", int'(ws_load), 0);
        prev_ph <= ws_phase;
    end

    initial begin
        int s, loads;
        repeat (2) tick();
        chk_zero("rst");
        rst_n = 1'b1;
        tick();

        // reset in the middle of FETCH
        start_run(L0, s);
        repeat (3) tick();
        chk("midrun_busy", int'(busy), 1);
        chk("midrun_load", int'(ws_load), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();

        // full run, with an ignored start mid-run and the one-phase instance alongside
        s = cyc + 1;
        push_run(s, L1, 8, 0);
        exp2_q.push_back('{s + 9, 3'd0, 1'b1, rom_vec(L1, 3'd0)});
        done2_q.push_back(s + 9);
        layer = L1; start = 1'b1; start2 = 1'b1;
        tick();
        start = 1'b0; start2 = 1'b0;
        chk("run1_load_setup", int'(ws_load), 0);
        chk("run1_busy", int'(busy), 1);
        tick();
        chk("run1_load_fetch", int'(ws_load), 1);
        chk("run1_cs", int'(ws_cs), int'(L1));
        while (cyc < s + 20) tick();
        layer = L2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(120, "run1_done");

        // start in the done cycle, back-pressure on phase 3
        start_run(L3, s);
        exp_q.delete(); done_q.delete();
        push_run(s, L3, 3, 18);
        while (cyc < s + 33) tick();
        w_ready = 1'b0;
        while (cyc < s + 53) begin
            tick();
            if (cyc >= s + 35) begin
                chk("stall_valid", int'(w_valid), 1);
                chk("stall_phase", int'(w_phase), 3);
                chkv("stall_data", w_data, rom_vec(L3, 3'd3));
                chk("stall_load", int'(ws_load), 0);
            end
        end
        w_ready = 1'b1;
        tick();
        chk("post_stall_ph", int'(ws_phase), 4);
        chk("post_stall_load", int'(ws_load), 0);
        wait_done(120, "run2_done");
        tick();

        // store never answers
        dead = 1'b1;
        start_run(L0, s);
        loads = 0;
        while (cyc < s + 22) begin
            loads += int'(ws_load);
            if (cyc == s + 16) begin
                chk("to_load_before", int'(ws_load), 1);
                chk("to_err_before", int'(err), 0);
            end
            if (cyc == s + 17) begin
                chk("to_load_drop", int'(ws_load), 0);
                chk("to_err", int'(err), 1);
                chk("to_busy", int'(busy), 0);
            end
            tick();
        end
        chk("to_load_cycles", loads, 16);
        dead = 1'b0;

        // next start clears err
        s = cyc + 1;
        push_run(s, L2, 8, 0);
        layer = L2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", int'(err), 0);
        wait_done(120, "run3_done");
        tick();

        // invalid layer code
        start_run(4'hF, s);
        chk("bad_layer_err", int'(err), 1);
        chk("bad_layer_busy", int'(busy), 0);
        loads = 0;
        repeat (12) begin
            loads += int'(ws_load);
            tick();
        end
        chk("bad_layer_noload", loads, 0);

        chk("one_phase_busy", int'(busy2), 0);
        chk("one_phase_err", int'(err2), 0);
        chk("one_phase_load", int'(ws_load2), 0);
        chk("one_phase_cs", int'(ws_cs2), int'(L1));
        chk("one_phase_wsph", int'(ws_phase2), 0);
        chk("xfer_left", exp_q.size() + exp2_q.size(), 0);
        chk("done_left", done_q.size() + done2_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
